// File: rtl/monta_bloco.sv
// Byte-stream to 128-bit block assembler with a valid/ready output register.
// Define MONTA_BLOCO_PKCS7_EN for PKCS#7 padding; otherwise pad bytes are PAD_BYTE.
module monta_bloco #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] bloco,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

`ifdef MONTA_BLOCO_PKCS7_EN
  localparam logic PKCS = 1'b1;
`else
  localparam logic PKCS = 1'b0;
`endif

  typedef enum logic [1:0] {COLETA, FECHA, EXTRA} state_t;

  state_t       state, state_next;
  logic [3:0]   cnt, cnt_next;
  logic         msg_end, msg_end_next;
  logic         pad_pend, pad_pend_next;
  logic [127:0] fill;
  logic [7:0]   pad_value;
  logic         byte_xfer;
  logic         move;

  assign in_ready  = rst_n & (state == COLETA);
  assign byte_xfer = in_valid & in_ready;
  // A closed block (or pending pad block) moves out once the output register is free
  assign move      = (state != COLETA) & (~out_valid | out_ready);

`ifdef MONTA_BLOCO_PKCS7_EN
  // Last byte lands at position cnt, so cnt+1 real bytes and 15-cnt pad bytes
  assign pad_value = 8'd15 - {4'd0, cnt};
`else
  assign pad_value = PAD_BYTE;
`endif

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      logic [7:0] lane;
      logic       wr;
      logic       pad;

      assign wr  = byte_xfer & (cnt == 4'(gi));
      assign pad = byte_xfer & in_last & (cnt < 4'(gi));
      assign fill[127-8*gi -: 8] = lane;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane <= 8'h00;
        end else if (wr) begin
          lane <= in_byte;
        end else if (pad) begin
          lane <= pad_value;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    msg_end_next  = msg_end;
    pad_pend_next = pad_pend;
    unique case (state)
      COLETA: begin
        if (byte_xfer) begin
          cnt_next = cnt + 4'd1;
          if (in_last || cnt == 4'd15) begin
            state_next    = FECHA;
            // PKCS message ending on a boundary defers out_last to the extra block
            pad_pend_next = PKCS & in_last & (cnt == 4'd15);
            msg_end_next  = in_last & ~pad_pend_next;
          end
        end
      end
      FECHA: begin
        if (move) begin
          cnt_next   = 4'd0;
          state_next = pad_pend ? EXTRA : COLETA;
        end
      end
      EXTRA: begin
        if (move) begin
          state_next    = COLETA;
          pad_pend_next = 1'b0;
        end
      end
      default: state_next = COLETA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLETA;
      cnt      <= 4'd0;
      msg_end  <= 1'b0;
      pad_pend <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      msg_end  <= msg_end_next;
      pad_pend <= pad_pend_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bloco     <= 128'h0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (move) begin
      bloco     <= (state == EXTRA) ? {16{8'h10}} : fill;
      out_valid <= 1'b1;
      out_last  <= (state == EXTRA) | msg_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
